mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multi-cycle multiply/divide unit for the MIPS datapath. Handles MULT, MULTU, DIV and DIVU, which the single-cycle ALU does not cover.
- Owns the architectural HI/LO registers. Execute stage starts it with a start/busy/done handshake and stalls on busy for MFHI/MFLO.
- Also accepts MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  rs operand (multiplicand/dividend).
- b  input  WIDTH  rt operand (multiplier/divisor).
- wr_hi  input  1  MTHI write strobe.
- wr_lo  input  1  MTLO write strobe.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; HI/LO valid.
- div_by_zero  output  1  set with done when a DIV/DIVU had b==0; held until next accepted start.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: one clock with RST high gives the following state.
  - State IDLE.
  - busy=0, done=0, div_by_zero=0, hi=0, lo=0.
  - Counter and datapath registers 0.
  - RST mid-operation aborts the operation; no done pulse.
- FSM states IDLE, RUN, FIN; busy = (state != IDLE).
- IDLE:
  - start=1 at edge k: latch op, a, b, go to RUN, count=0, clear div_by_zero.
  - Signed ops latch |a|, |b| and record sign_a, sign_b.
- RUN: one iteration per edge. Edges k+1..k+WIDTH; at edge k+WIDTH (count==WIDTH-1) go to FIN.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; quotient bit = 1 when partial remainder >= divisor.
- FIN, edge k+WIDTH+1:
  - Apply sign correction.
  - Write hi/lo.
  - Register done=1, return to IDLE.
  - done is high for exactly the cycle after edge k+WIDTH+1.
- Latency: start to done-visible is WIDTH+2 edges (34 for WIDTH=32). It is fixed for all ops and operands, including divide-by-zero.
- Multiply results:
  - {hi,lo} = full 2*WIDTH product.
  - MULT negates the product when sign_a^sign_b.
- Divide results:
  - lo = quotient, hi = remainder.
  - DIV: quotient negated when sign_a^sign_b; remainder carries sign of dividend (sign_a).
- Divide by zero:
  - lo = all ones, hi = a as latched before abs (raw dividend), div_by_zero=1.
  - No sign correction applied.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No flag.
- start while busy (RUN/FIN): ignored and not queued; operands are not re-latched.
- start on the cycle done is high: state is IDLE, so it is accepted. Back-to-back throughput is one op per WIDTH+2 cycles.
- MTHI/MTLO writes:
  - wr_hi/wr_lo are honoured only in IDLE with start=0; hi/lo update at that edge.
  - Ignored while busy.
  - start and wr_* in the same IDLE cycle: start wins, write dropped.
  - wr_hi and wr_lo together: both updated with wdata.
- hi/lo hold their previous values during RUN. They change only at FIN or on an accepted write.
- done, busy and div_by_zero are registered outputs (no combinational path from inputs).

Test Plan:
1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at edge 0 -> busy high edges 1..33; done pulse after edge 34; hi=0xFFFFFFFE lo=0x00000001.
2. MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB. Then MULT 0x80000000*0x80000000 -> hi=0x40000000 lo=0.
3. DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF. DIVU a=100 b=7 -> lo=14 hi=2. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
4. DIVU a=0x12345678 b=0 -> done at same latency; lo=0xFFFFFFFF, hi=0x12345678, div_by_zero=1. Next start clears div_by_zero.
5. Handshake:
   - start during RUN with new operands -> ignored; result matches first op.
   - start on done cycle -> accepted; second done exactly 34 edges later.
   - wr_hi=1 wdata=0xCAFEF00D while busy -> hi unchanged. Same write in IDLE -> hi=0xCAFEF00D.
6. RST asserted for one edge at edge 10 of a DIV -> busy=0, hi=lo=0, no done pulse. A new MULTU 3*5 then gives lo=15 hi=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit that owns the HI/LO registers.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division, one bit per clock.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + (2*WIDTH)'(1);
    endfunction

    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x, input logic is_signed);
        return (is_signed && x[WIDTH-1]) ? neg_w(x) : x;
    endfunction

    state_t            state, state_nxt;
    logic [CW-1:0]     count;
    logic [1:0]        op_q;
    logic              sign_a, sign_b;
    logic [WIDTH-1:0]  raw_a, opnd, acc_hi, acc_lo;
    logic              op_signed;
    logic [WIDTH-1:0]  mag_a, mag_b;
    logic              is_div, is_signed_q, by_zero;
    logic [WIDTH:0]    mul_sum, div_trial, div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]  res_hi, res_lo;

    assign busy = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (count == LAST) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand magnitudes at issue; op[0]==0 selects the signed variants.
    always_comb begin
        op_signed = ~op[0];
        mag_a     = abs_w(a, op_signed);
        mag_b     = abs_w(b, op_signed);
    end

    // Per-iteration step and the sign-corrected final result.
    always_comb begin
        is_div      = op_q[1];
        is_signed_q = ~op_q[0];
        by_zero     = (opnd == '0);
        mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_trial   = {acc_hi, acc_lo[WIDTH-1]};
        div_diff    = div_trial - {1'b0, opnd};
        prod        = {acc_hi, acc_lo};
        res_hi      = acc_hi;
        res_lo      = acc_lo;
        if (!is_div) begin
            if (is_signed_q && (sign_a ^ sign_b)) prod = neg_2w(prod);
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (by_zero) begin
            res_hi = raw_a;
            res_lo = '1;
        end else begin
            res_lo = (is_signed_q && (sign_a ^ sign_b)) ? neg_w(acc_lo) : acc_lo;
            res_hi = (is_signed_q && sign_a) ? neg_w(acc_hi) : acc_hi;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count       <= '0;
            op_q        <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            raw_a       <= '0;
            opnd        <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q        <= op;
                        sign_a      <= op_signed & a[WIDTH-1];
                        sign_b      <= op_signed & b[WIDTH-1];
                        raw_a       <= a;
                        count       <= '0;
                        acc_hi      <= '0;
                        div_by_zero <= 1'b0;
                        acc_lo      <= op[1] ? mag_a : mag_b;
                        opnd        <= op[1] ? mag_b : mag_a;
                    end else begin
                        if (wr_hi) hi <= wdata;
                        if (wr_lo) lo <= wdata;
                    end
                end
                RUN: begin
                    count <= count + CW'(1);
                    if (is_div) begin
                        if (!div_diff[WIDTH]) begin
                            acc_hi <= div_diff[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_trial[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                    end
                end
                FIN: begin
                    hi          <= res_hi;
                    lo          <= res_lo;
                    div_by_zero <= is_div & by_zero;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO/flag are queued at issue
// and compared when done pulses; handshake, MTHI/MTLO and reset cases are covered.
module tb_mult_div_unit;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } res_t;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        wr_hi = 1'b0, wr_lo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int   total = 0;
    int   bad = 0;
    int   since_start = 0;
    int   done_cnt = 0;
    res_t sb[$];
    string tq[$];
    res_t mon_e;
    string mon_t;

    mult_div_unit #(.WIDTH(32)) dut (
        .CLK(clk), .RST(RST), .start(start), .op(op), .a(a), .b(b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic res_t mk(input logic [31:0] h, input logic [31:0] l, input logic z);
        res_t r;
        r.hi = h; r.lo = l; r.dbz = z;
        return r;
    endfunction

    // Reference built on native 64-bit arithmetic; SV division truncates toward zero.
    function automatic res_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        res_t r;
        longint sx, sy, p;
        longint unsigned up;
        int q, m;
        r.dbz = 1'b0;
        r.hi = '0;
        r.lo = '0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0: begin p = sx * sy; {r.hi, r.lo} = p; end
            2'd1: begin up = {32'b0, x} * {32'b0, y}; {r.hi, r.lo} = up; end
            2'd2: begin
                if (y == 0) begin r.hi = x; r.lo = '1; r.dbz = 1'b1; end
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin r.hi = '0; r.lo = x; end
                else begin q = $signed(x) / $signed(y); m = $signed(x) % $signed(y); r.lo = q; r.hi = m; end
            end
            default: begin
                if (y == 0) begin r.hi = x; r.lo = '1; r.dbz = 1'b1; end
                else begin r.lo = x / y; r.hi = x % y; end
            end
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                mon_t = tq.pop_front();
                chk({mon_t, "_hi"}, hi, mon_e.hi);
                chk({mon_t, "_lo"}, lo, mon_e.lo);
                chk({mon_t, "_dbz"}, div_by_zero, mon_e.dbz);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        since_start++;
    endtask

    task automatic issue(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input res_t e);
        op = o; a = x; b = y; start = 1'b1;
        sb.push_back(e);
        tq.push_back(tag);
        tick();
        since_start = 1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic busy_ok;
        busy_ok = busy;
        while (!done && since_start < 100) begin
            tick();
            if (!done) busy_ok &= busy;
        end
        if (!done) begin
            chk({tag, "_timeout"}, 0, 1);
        end else begin
            chk({tag, "_lat"}, since_start, 34);
            chk({tag, "_busy_run"}, busy_ok, 1);
            chk({tag, "_busy_end"}, busy, 0);
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input res_t e);
        issue(tag, o, x, y, e);
        wait_done(tag);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          dc;

        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        RST = 1'b0;
        tick();

        run("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'hFFFF_FFFE, 32'h0000_0001, 1'b0));
        run("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7, mk(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0));
        run("mult_min", 2'd0, 32'h8000_0000, 32'h8000_0000, mk(32'h4000_0000, 32'h0, 1'b0));
        run("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0));
        run("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h0, 32'h8000_0000, 1'b0));
        run("divu_zero", 2'd3, 32'h1234_5678, 32'h0, mk(32'h1234_5678, 32'hFFFF_FFFF, 1'b1));
        tick(); tick(); tick();
        chk("dbz_hold", div_by_zero, 1);
        issue("divu", 2'd3, 32'd100, 32'd7, mk(32'd2, 32'd14, 1'b0));
        chk("dbz_clear", div_by_zero, 0);
        wait_done("divu");
        run("div_zero", 2'd2, 32'hFFFF_FF00, 32'h0, mk(32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1));

        for (int i = 0; i < 10; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 4 == 3) ? 32'h0 : $urandom;
            if (ro[1] && (i % 3 == 0)) rb = $urandom_range(1, 50);
            run($sformatf("rand%0d", i), ro, ra, rb, model(ro, ra, rb));
            if (i % 2 == 1) tick();
        end

        tick();
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h1111_1111;
        tick();
        wr_hi = 1'b0; wr_lo = 1'b0;
        chk("wr_both_hi", hi, 32'h1111_1111);
        chk("wr_both_lo", lo, 32'h1111_1111);

        issue("ignore", 2'd1, 32'd6, 32'd7, mk(32'h0, 32'd42, 1'b0));
        tick(); tick();
        wr_hi = 1'b1; wdata = 32'hCAFE_F00D;
        tick();
        wr_hi = 1'b0;
        chk("busy_wr_hi", hi, 32'h1111_1111);
        op = 2'd3; a = 32'd1000; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_hold_lo", lo, 32'h1111_1111);
        wait_done("ignore");

        wr_hi = 1'b1; wdata = 32'hCAFE_F00D;
        tick();
        wr_hi = 1'b0;
        chk("idle_wr_hi", hi, 32'hCAFE_F00D);
        chk("idle_keep_lo", lo, 32'd42);
        wr_lo = 1'b1; wdata = 32'h0BAD_BEEF;
        tick();
        wr_lo = 1'b0;
        chk("idle_wr_lo", lo, 32'h0BAD_BEEF);
        chk("idle_keep_hi", hi, 32'hCAFE_F00D);

        wr_lo = 1'b1; wdata = 32'hDEAD_DEAD;
        issue("start_wins", 2'd3, 32'd1000, 32'd3, mk(32'd1, 32'd333, 1'b0));
        wr_lo = 1'b0;
        chk("start_wins_lo", lo, 32'h0BAD_BEEF);
        wait_done("start_wins");
        run("b2b", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'h0, 32'h1, 1'b0));

        tick();
        issue("aborted", 2'd2, 32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0));
        while (since_start < 9) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        sb.delete();
        tq.delete();
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_done", done, 0);
        dc = done_cnt;
        repeat (40) tick();
        chk("abort_no_done", done_cnt, dc);
        run("after_rst", 2'd1, 32'd3, 32'd5, mk(32'h0, 32'd15, 1'b0));

        tick(); tick();
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
